// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - push/pop sequencer driving the sp register controls and a req/ack memory port.
module stack_ctrl #(
    parameter int BITS  = 8,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [BITS-1:0] push_data,
    input  logic [BITS-1:0] sp,
    output logic            sp_we,
    output logic            sp_op,
    output logic            mem_req,
    output logic            mem_we,
    output logic [BITS-1:0] mem_addr,
    output logic [BITS-1:0] mem_wdata,
    input  logic [BITS-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] pop_data,
    output logic            err,
    output logic [BITS-1:0] depth
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_MEM,
        S_PUSH_SP,
        S_POP_SP,
        S_POP_MEM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [BITS-1:0] L_DEPTH = BITS'(DEPTH);

    state_t          r_state;
    logic            r_sp_we;
    logic            r_sp_op;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [BITS-1:0] r_mem_addr;
    logic [BITS-1:0] r_mem_wdata;
    logic            r_done;
    logic            r_err;
    logic [BITS-1:0] r_pop_data;
    logic [BITS-1:0] r_depth;

    logic w_full;
    logic w_empty;

    assign w_full  = (r_depth == L_DEPTH);
    assign w_empty = (r_depth == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sp_we     <= 1'b0;
            r_sp_op     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_pop_data  <= '0;
            r_depth     <= '0;
        end else begin
            r_sp_we <= 1'b0;
            r_sp_op <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((push && pop) || (push && w_full) || (pop && w_empty)) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else if (push) begin
                        r_state     <= S_PUSH_MEM;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= sp;
                        r_mem_wdata <= push_data;
                    end else if (pop) begin
                        r_state <= S_POP_SP;
                        r_sp_we <= 1'b1;
                        r_sp_op <= 1'b0;
                        r_depth <= r_depth - 1'b1;
                    end
                end
                S_PUSH_MEM: begin
                    if (mem_ack) begin
                        r_state   <= S_PUSH_SP;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_sp_we   <= 1'b1;
                        r_depth   <= r_depth + 1'b1;
                    end
                end
                S_PUSH_SP: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_POP_SP: begin
                    // sp decrements on this same edge, so address the slot below the old value
                    r_state    <= S_POP_MEM;
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= sp - 1'b1;
                end
                S_POP_MEM: begin
                    if (mem_ack) begin
                        r_state    <= S_DONE;
                        r_mem_req  <= 1'b0;
                        r_pop_data <= mem_rdata;
                        r_done     <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sp_we     = r_sp_we;
    assign sp_op     = r_sp_op;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign pop_data  = r_pop_data;
    assign depth     = r_depth;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed scoreboard bench for stack_ctrl with sp register and memory models.
module tb_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] push_data;
    logic [7:0] sp_reg = 8'h00;
    logic       sp_we;
    logic       sp_op;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       busy;
    logic       done;
    logic [7:0] pop_data;
    logic       err;
    logic [7:0] depth;

    stack_ctrl #(.BITS(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .sp        (sp_reg),
        .sp_we     (sp_we),
        .sp_op     (sp_op),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .pop_data  (pop_data),
        .err       (err),
        .depth     (depth)
    );

    always #5 clk = ~clk;

    // unreset pointer register as seen by the controller
    always @(posedge clk) begin
        if (sp_we) sp_reg <= sp_op ? sp_reg + 8'd1 : sp_reg - 8'd1;
    end

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] exp_pop_q[$];
    logic [7:0] mdl_stack[$];
    logic [7:0] mem [256];
    logic [7:0] mdl_sp = 8'h00;
    int         mdl_depth = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input bit ip, input bit iq, input logic [7:0] d,
                          input int dly, input bit poke, input string tag);
        bit         exp_err;
        bit         fin = 1'b0;
        txn_t       e;
        int         cyc = 0, n_we = 0, n_done = 0, n_err = 0, n_req = 0;
        int         done_at = 0, err_at = 0;
        logic       op_seen = 1'b0;
        logic [7:0] a0 = 8'h00, w0 = 8'h00;
        exp_err = (ip && iq) || (ip && mdl_depth == 16) || (iq && mdl_depth == 0);
        if (!exp_err) begin
            if (ip) exp_q.push_back('{1'b1, mdl_sp, d});
            else begin
                exp_q.push_back('{1'b0, mdl_sp - 8'd1, 8'h00});
                exp_pop_q.push_back(mdl_stack[$]);
            end
        end
        @(negedge clk);
        push = ip; pop = iq; push_data = d;
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        while (!fin && cyc < 40) begin
            cyc++;
            mem_ack = 1'b0;
            if (sp_we) begin n_we++; op_seen = sp_op; end
            if (done) begin n_done++; done_at = cyc; end
            if (err) begin n_err++; err_at = cyc; end
            if (mem_req) begin
                n_req++;
                if (n_req == 1) begin
                    if (exp_q.size() == 0) chk({tag, "_unexpected_req"}, 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk({tag, "_we"}, mem_we, e.we);
                        chk({tag, "_addr"}, mem_addr, e.addr);
                        if (e.we) chk({tag, "_wdata"}, mem_wdata, e.data);
                    end
                    a0 = mem_addr; w0 = mem_wdata;
                end else begin
                    chk({tag, "_addr_stable"}, mem_addr, a0);
                    chk({tag, "_wdata_stable"}, mem_wdata, w0);
                end
                if (n_req == dly + 1) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem[mem_addr];
                end
            end
            push = poke && busy;
            if (!busy) fin = 1'b1;
            else @(negedge clk);
        end
        push = 1'b0; mem_ack = 1'b0;
        chk({tag, "_finished"}, fin, 1'b1);
        chk({tag, "_err_cnt"}, n_err, exp_err ? 1 : 0);
        chk({tag, "_done_cnt"}, n_done, exp_err ? 0 : 1);
        chk({tag, "_spwe_cnt"}, n_we, exp_err ? 0 : 1);
        chk({tag, "_req_cycles"}, n_req, exp_err ? 0 : dly + 1);
        if (exp_err) chk({tag, "_err_at"}, err_at, 1);
        else begin
            chk({tag, "_sp_op"}, op_seen, ip);
            chk({tag, "_done_at"}, done_at, 3 + dly);
            if (ip) begin
                mdl_stack.push_back(d);
                mdl_depth++;
                mdl_sp = mdl_sp + 8'd1;
            end else begin
                void'(mdl_stack.pop_back());
                mdl_depth--;
                mdl_sp = mdl_sp - 8'd1;
                chk({tag, "_pop_data"}, pop_data, exp_pop_q.pop_front());
            end
        end
        chk({tag, "_depth"}, depth, mdl_depth);
        chk({tag, "_sp"}, sp_reg, mdl_sp);
    endtask

    initial begin
        int k;
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = 8'h00;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_spwe", sp_we, 1'b0);
        chk("rst_spop", sp_op, 1'b0);
        chk("rst_depth", depth, 8'h00);
        chk("rst_popdata", pop_data, 8'h00);
        chk("rst_addr", mem_addr, 8'h00);
        rst = 1'b0;

        run_op(1, 0, 8'hA5, 0, 0, "push_a5");
        run_op(0, 1, 8'h00, 0, 0, "pop_a5");
        run_op(1, 0, 8'h11, 0, 0, "push_11");
        run_op(1, 0, 8'h22, 1, 0, "push_22");
        run_op(1, 0, 8'h33, 0, 0, "push_33");
        run_op(0, 1, 8'h00, 0, 0, "pop_33");
        run_op(0, 1, 8'h00, 2, 0, "pop_22");
        run_op(0, 1, 8'h00, 0, 0, "pop_11");
        run_op(0, 1, 8'h00, 0, 0, "pop_empty");
        run_op(1, 1, 8'h77, 0, 0, "both_empty");
        run_op(1, 0, 8'hC3, 5, 1, "push_stall");
        run_op(1, 1, 8'h44, 0, 0, "both_depth1");
        run_op(0, 1, 8'h00, 3, 1, "pop_stall");
        for (int i = 0; i < 16; i++) run_op(1, 0, 8'(8'h80 + i), i % 3, 0, $sformatf("fill_%0d", i));
        run_op(1, 0, 8'hEE, 0, 0, "push_full");

        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        k = 0;
        while (!mem_req && k < 10) begin @(negedge clk); k++; end
        chk("rst_mid_reach", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_req", mem_req, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_depth", depth, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        mdl_sp = mdl_sp - 8'd1;
        mdl_depth = 0;
        mdl_stack.delete();
        chk("rst_mid_sp", sp_reg, mdl_sp);
        run_op(1, 0, 8'h5A, 0, 0, "push_after_rst");
        run_op(0, 1, 8'h00, 0, 0, "pop_after_rst");
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
